seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: a configurable pattern of up to MAX_LEN bits is matched
// (overlapping) against a din_valid-qualified bit stream, with an optional match target.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               din_valid,
    input  logic               din,
    input  logic               abort,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [3:0]       MAX_L   = 4'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] r_hist;
    logic [3:0]         r_len;
    logic [3:0]         r_fill;
    logic [CNT_W-1:0]   r_tgt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_match;
    logic               r_cfg_err;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_ready;

    logic               w_len_ok;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [3:0]         w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_len_ok    = (cfg_len != 4'd0) && (cfg_len <= MAX_L);
    assign w_hist_next = {r_hist[MAX_LEN-2:0], din};
    assign w_fill_next = (r_fill == MAX_L) ? r_fill : r_fill + 4'd1;
    assign w_cnt_next  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Only the low r_len bits of history take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (i < int'(r_len));
    end

    assign w_hit = (((w_hist_next ^ r_pat) & w_mask) == '0) && (w_fill_next >= r_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pat       <= '0;
            r_hist      <= '0;
            r_len       <= 4'd1;
            r_fill      <= '0;
            r_tgt       <= '0;
            r_cnt       <= '0;
            r_match     <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cfg_valid && r_cfg_ready) begin
                        if (w_len_ok) begin
                            r_pat       <= cfg_pattern;
                            r_len       <= cfg_len;
                            r_tgt       <= cfg_target;
                            r_cnt       <= '0;
                            r_hist      <= '0;
                            r_fill      <= '0;
                            r_state     <= ST_RUN;
                            r_busy      <= 1'b1;
                            r_done      <= 1'b0;
                            r_cfg_ready <= 1'b0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort wins over a bit arriving on the same edge.
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (din_valid) begin
                        r_hist <= w_hist_next;
                        r_fill <= w_fill_next;
                        if (w_hit) begin
                            r_match <= 1'b1;
                            r_cnt   <= w_cnt_next;
                            if ((r_tgt != '0) && (w_cnt_next == r_tgt)) begin
                                r_state     <= ST_DONE;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_cfg_ready <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
endmodule
